fft_input_loader: RTL and testbench
===================================

# fft_input_loader

Serial-to-4-lane frame loader at the head of the pipelined FFT. It accepts one complex sample per cycle in natural order and buffers each N-point frame in a ping-pong memory. It then emits the frame as N/4 consecutive 4-lane words, in the order the first butterfly/commutator stage consumes: lane k of word j carries sample j + k·N/4. It also generates the `start` pulse that aligns the commutator counters downstream.

## Interface
- `nb`, 16, width of one complex sample (real+imag packed); the FFT sample-format width.
- `N`, 16, FFT points per frame; power of two, ≥ 8.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  `in_data` holds a sample this cycle.
- `in_data`  in  nb  serial sample, natural order.
- `start`  out  1  one-cycle pulse coincident with word 0 of each frame.
- `out_valid`  out  1  `output_data` holds a valid word.
- `output_data`  out  4·nb  lane 0 in [nb-1:0], lane 1 in [2nb-1:nb], lane 2 in [3nb-1:2nb], lane 3 in [4nb-1:3nb].

## Operation
- Two banks of N×nb storage, A and B. The write side fills one bank while the read side drains the other.
- **Write side**
  - Write pointer `wp` is log2(N) bits. Each accepted sample (`in_valid`=1) is stored at `bank[wsel][wp]`, then `wp` increments.
  - When `wp` wraps from N-1 to 0:
    - the bank is marked full;
    - `wsel` toggles;
    - a pending-frame flag is set for that bank.
  - `in_valid` gaps of any length are allowed. `wp` holds during gaps.
- **Read side** FSM: IDLE, READ.
  - IDLE → READ when a bank is full. The read side latches that bank as `rsel` and sets `rp`=0.
  - In READ, each cycle: `output_data` ← {bank[rsel][rp+3N/4], bank[rsel][rp+N/2], bank[rsel][rp+N/4], bank[rsel][rp]}, then `rp` increments. `rp` is log2(N)-2 bits.
  - At `rp`=N/4-1 the bank is marked empty.
    - If the other bank is already full, stay in READ, switch `rsel`, and restart at `rp`=0 with no idle cycle.
    - Otherwise return to IDLE.
- Overflow cannot occur: a readout takes N/4 cycles and a fill takes ≥ N cycles. The bench asserts that a bank being written is never full.
- **Reset (any time, including mid-frame or mid-readout)**
  - `wp`, `rp`, `wsel`, `rsel` ← 0; both banks marked empty; FSM → IDLE.
  - Partial frames are discarded. Memory contents are not cleared.

## Timing
- Reset values: `start`=0, `out_valid`=0, `output_data`=0.
- All outputs are registered.
- **Latency.** Let the last sample of a frame be accepted at edge E, with the read side idle. Word 0 is then valid with `start`=1 and `out_valid`=1 in the cycle following edge E+1. Words 1..N/4-1 follow on consecutive cycles.
- `start` is high only with word 0 and is never asserted in any other cycle.
- `out_valid` is high for exactly N/4 consecutive cycles per frame. Back-to-back frames produce continuous `out_valid`, with `start` marking each frame's word 0.
- When `out_valid`=0, `output_data` holds its last value.
- Storage is an asynchronous-read register array. Write and read of the same bank in the same cycle never occur.

## Test plan
- **Reset values:** Hold `reset_n`=0 for 3 cycles → `start`=0, `out_valid`=0, `output_data`=0. Release; with no `in_valid`, outputs stay 0.
- **Single frame, N=16, nb=16:** Drive `in_data`=0..15 on 16 consecutive cycles.
  - One cycle after the last accept: word0 = {12,8,4,0} (lane3..lane0), with `start`=1.
  - Then {13,9,5,1}, {14,10,6,2}, {15,11,7,3} with `start`=0.
  - `out_valid` high for exactly 4 cycles.
- **Gapped input:** Send the same 16 samples with `in_valid` toggled 1/0/0 → identical 4 words. Word0 appears exactly one cycle after the 16th accept.
- **Continuous stream:** Send 3 frames (values 0..47) with no gaps.
  - 3 bursts of 4 words; `start` once per burst.
  - Frame 2 word0 = {28,24,20,16}; frame 3 word0 = {44,40,36,32}.
  - No sample lost or duplicated.
- **Reset mid-frame:** Send 10 samples, pulse `reset_n` low, then send 16 samples 100..115 → only one frame emitted, word0 = {112,108,104,100}.
- **Reset mid-readout:** Assert reset during word 2 of a readout → `out_valid` and `start` drop immediately and the remaining words are never emitted.

Source files
------------

// File: rtl/fft_input_loader.sv
// rtl/fft_input_loader.sv - serial-to-4-lane ping-pong frame loader for the pipelined FFT
//
// Buffers N-point frames of serial complex samples in two banks and replays each
// completed frame as N/4 words of 4 lanes, with lane k of word j = sample j + k*N/4.
//
// Ports:
//   clk          sole clock, rising edge
//   reset_n      asynchronous active-low reset
//   in_valid     in_data holds a sample this cycle
//   in_data      serial sample, natural order (nb bits)
//   start        one-cycle pulse with word 0 of each frame
//   out_valid    output_data holds a valid word
//   output_data  4 lanes, lane 0 in the least significant nb bits

module fft_input_loader #(
   parameter int nb = 16,
   parameter int N  = 16
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            in_valid,
   input  logic [nb-1:0]   in_data,
   output logic            start,
   output logic            out_valid,
   output logic [4*nb-1:0] output_data
);

   localparam int LW = $clog2(N);
   localparam int RW = LW - 2;
   localparam int Q  = N / 4;

   typedef enum logic {IDLE, READ} state_t;

   logic [nb-1:0] mem [2][N];

   logic [LW-1:0] wp;
   logic          wsel;
   logic [1:0]    full;      // per bank: frame complete and not yet drained
   logic [RW-1:0] rp;
   logic          rsel;
   state_t        state, state_nx;

   logic          emit;
   logic          rb;
   logic [RW-1:0] ri;
   logic          rsel_nx;
   logic [RW-1:0] rp_nx;
   logic [1:0]    clr;
   logic [1:0]    set;
   logic [4*nb-1:0] word;

   // Storage has no reset; partial frames are simply overwritten.
   always_ff @(posedge clk) begin
      if (in_valid)
         mem[wsel][wp] <= in_data;
   end

   // Read side: IDLE emits word 0 directly when a bank is full, which gives
   // one-cycle latency from the last accepted sample to word 0.
   always_comb begin
      state_nx = state;
      emit     = 1'b0;
      rb       = rsel;
      ri       = rp;
      rsel_nx  = rsel;
      rp_nx    = rp;
      clr      = 2'b00;
      case (state)
         IDLE: begin
            if (|full) begin
               emit = 1'b1;
               rb   = full[0] ? 1'b0 : 1'b1;
               ri   = '0;
            end
         end
         READ: emit = 1'b1;
         default: state_nx = IDLE;
      endcase
      if (emit) begin
         rsel_nx  = rb;
         rp_nx    = ri + 1'b1;
         state_nx = READ;
         if (ri == RW'(Q - 1)) begin
            clr[rb] = 1'b1;
            // Other bank already waiting: chain straight into its word 0.
            if (full[~rb]) begin
               rsel_nx = ~rb;
               rp_nx   = '0;
            end else begin
               state_nx = IDLE;
            end
         end
      end
   end

   // Lane k address is {k, ri}, i.e. ri + k*N/4.
   always_comb begin
      word = '0;
      for (int k = 0; k < 4; k++)
         word[k*nb +: nb] = mem[rb][{2'(k), ri}];
   end

   assign set = (in_valid && wp == LW'(N - 1)) ? (2'b01 << wsel) : 2'b00;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wp          <= '0;
         wsel        <= 1'b0;
         full        <= 2'b00;
         rp          <= '0;
         rsel        <= 1'b0;
         state       <= IDLE;
         start       <= 1'b0;
         out_valid   <= 1'b0;
         output_data <= '0;
      end else begin
         if (in_valid) begin
            wp <= wp + 1'b1;
            if (wp == LW'(N - 1))
               wsel <= ~wsel;
         end
         // Set and clear always target different banks.
         full      <= (full & ~clr) | set;
         rp        <= rp_nx;
         rsel      <= rsel_nx;
         state     <= state_nx;
         out_valid <= emit;
         start     <= emit && (ri == '0);
         if (emit)
            output_data <= word;
      end
   end

endmodule

// File: tb/tb_fft_input_loader.sv
// tb/tb_fft_input_loader.sv - self-checking bench for fft_input_loader

module tb_fft_input_loader;

   localparam int NB = 16;
   localparam int NP = 16;

   logic            clk = 1'b0;
   logic            reset_n;
   logic            in_valid;
   logic [NB-1:0]   in_data;
   logic            start;
   logic            out_valid;
   logic [4*NB-1:0] output_data;

   fft_input_loader #(.nb(NB), .N(NP)) dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
      .start(start), .out_valid(out_valid), .output_data(output_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] data;
      logic        st;
   } exp_t;

   typedef struct {
      int          pre;
      int          base;
      int          gap;
      logic [63:0] w0;
   } vec_t;

   int n_pass  = 0;
   int n_total = 0;
   int n_start = 0;

   logic [NB-1:0] acc_q[$];
   exp_t          exp_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s got %h expected %h", name, act, req);
   endtask

   // Reference: frame of N samples -> N/4 words, lane k of word j = sample j + k*N/4.
   task automatic model_accept(input logic [NB-1:0] v);
      exp_t e;
      acc_q.push_back(v);
      if (acc_q.size() == NP) begin
         for (int j = 0; j < NP/4; j++) begin
            for (int k = 0; k < 4; k++)
               e.data[k*NB +: NB] = acc_q[j + k*NP/4];
            e.st = (j == 0);
            exp_q.push_back(e);
         end
         acc_q.delete();
      end
   endtask

   function automatic logic [63:0] fw(input int base, input int j);
      return {16'(base + j + 12), 16'(base + j + 8), 16'(base + j + 4), 16'(base + j)};
   endfunction

   task automatic send(input int v, input int gap);
      in_data  = NB'(v);
      in_valid = 1'b1;
      @(posedge clk);
      model_accept(NB'(v));
      #1;
      in_valid = 1'b0;
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      acc_q.delete();
      exp_q.delete();
      @(posedge clk);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   // Scoreboard monitor: every valid word must match the reference in order.
   always @(negedge clk) begin
      if (reset_n) begin
         check("no_overflow", 64'(dut.full[dut.wsel]), 64'd0);
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               n_total++;
               $display("FAIL unexpected_word got %h expected none", output_data);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("sb_data", output_data, e.data);
               check("sb_start", 64'(start), 64'(e.st));
            end
         end else begin
            check("start_idle", 64'(start), 64'd0);
         end
         if (start) n_start++;
      end
   end

   initial begin
      #500000;
      $display("FAIL timeout got running expected done");
      $fatal(1);
   end

   initial begin
      vec_t vt[4];
      int   cyc, acc, nv;

      vt[0] = '{pre: 0,  base: 0,   gap: 0, w0: 64'h000c_0008_0004_0000};
      vt[1] = '{pre: 0,  base: 0,   gap: 2, w0: 64'h000c_0008_0004_0000};
      vt[2] = '{pre: 0,  base: 200, gap: 1, w0: 64'h00d4_00d0_00cc_00c8};
      vt[3] = '{pre: 10, base: 100, gap: 0, w0: 64'h0070_006c_0068_0064};

      reset_n  = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_start", 64'(start), 64'd0);
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_data", output_data, 64'd0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("idle_start", 64'(start), 64'd0);
      check("idle_valid", 64'(out_valid), 64'd0);
      check("idle_data", output_data, 64'd0);
      @(posedge clk);
      #1;

      // Single frames: latency, word order, start, exact burst length.
      for (int t = 0; t < 4; t++) begin
         if (vt[t].pre > 0) begin
            for (int i = 0; i < vt[t].pre; i++) send(500 + i, 0);
            do_reset();
         end
         for (int i = 0; i < NP; i++) send(vt[t].base + i, (i == NP-1) ? 0 : vt[t].gap);
         @(negedge clk);
         check("lat_early", 64'(out_valid), 64'd0);
         @(posedge clk);
         @(negedge clk);
         check("w0_valid", 64'(out_valid), 64'd1);
         check("w0_start", 64'(start), 64'd1);
         check("w0_data", output_data, vt[t].w0);
         for (int j = 1; j < NP/4; j++) begin
            @(negedge clk);
            check("wj_valid", 64'(out_valid), 64'd1);
            check("wj_start", 64'(start), 64'd0);
            check("wj_data", output_data, fw(vt[t].base, j));
         end
         @(negedge clk);
         check("burst_end", 64'(out_valid), 64'd0);
         check("hold_data", output_data, fw(vt[t].base, NP/4 - 1));
         @(posedge clk);
         #1;
      end

      // Continuous stream of three frames.
      n_start = 0;
      for (int i = 0; i < 3*NP; i++) send(i, 0);
      repeat (10) @(posedge clk);
      #1;
      check("cont_starts", 64'(n_start), 64'd3);
      check("cont_drained", 64'(exp_q.size()), 64'd0);

      // Reset during word 2 of a readout.
      for (int i = 0; i < NP; i++) send(300 + i, 0);
      @(posedge clk);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      check("mid_w2", output_data, fw(300, 2));
      #2;
      reset_n = 1'b0;
      acc_q.delete();
      exp_q.delete();
      #1;
      check("mid_rst_valid", 64'(out_valid), 64'd0);
      check("mid_rst_start", 64'(start), 64'd0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      nv = 0;
      repeat (10) begin
         @(negedge clk);
         if (out_valid) nv++;
      end
      check("mid_no_more", 64'(nv), 64'd0);
      @(posedge clk);
      #1;

      // Randomized gaps and data against the reference model.
      cyc = 0;
      acc = 0;
      while (cyc < 3000 && acc < 6*NP) begin
         in_valid = 1'($urandom_range(0, 1));
         in_data  = NB'($urandom);
         @(posedge clk);
         if (in_valid) begin
            model_accept(in_data);
            acc++;
         end
         #1;
         cyc++;
      end
      in_valid = 1'b0;
      check("rand_accepted", 64'(acc), 64'(6*NP));
      repeat (12) @(posedge clk);
      #1;
      check("rand_drained", 64'(exp_q.size()), 64'd0);
      check("rand_partial", 64'(acc_q.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
